adc_capture: RTL and testbench
==============================

// Module: adc_capture
// PURPOSE
//  Parametrised ADC capture front-end replacing the fixed 4x10-bit ADC packer ahead of the clk50->clk125 FIFO.
//  Registers parallel ADC samples, decimates, packs LANES samples per FIFO word, and runs free-run or triggered
//  fixed-length frames. Honours FIFO Almost_Full by dropping whole words, counting drops and tracking ADC overrange.
// PARAMETERS
//  SAMPLE_W  10  ADC sample width (adpin)
//  LANES     4   samples packed per output word; WORD_W = SAMPLE_W*LANES (localparam)
//  DECIM_W   8   width of decimation control
//  LEN_W     16  width of frame length (in words)
// PORTS
//  clk50       in   1        sample clock (ADC clock domain)
//  reset       in   1        synchronous, active-high
//  adpin       in   SAMPLE_W ADC parallel data
//  adcovr      in   1        ADC overrange, aligned with adpin
//  arm         in   1        level: 1 = run/arm capture, 0 = stop and return to IDLE
//  trig_mode   in   1        0 = free-run, 1 = triggered frame
//  trig_rising in   1        1 = rising-edge trigger, 0 = falling-edge
//  trig_level  in   SAMPLE_W trigger threshold (unsigned)
//  decim       in   DECIM_W  keep 1 of every decim+1 samples
//  frame_len   in   LEN_W    words per triggered frame
//  afull       in   1        FIFO Almost_Full
//  odata       out  WORD_W   packed word; lane 0 (oldest sample) in bits [SAMPLE_W-1:0]
//  wren        out  1        one-cycle FIFO write strobe for odata
//  busy        out  1        state is WAIT_TRIG or CAPTURE
//  done        out  1        triggered frame complete (held until arm=0)
//  ovr_sticky  out  1        adcovr seen on an accepted sample since last arm
//  drop_cnt    out  16       words dropped due to afull, saturating at 16'hFFFF
// BEHAVIOUR
//  Reset: state IDLE; odata, wren, busy, done, ovr_sticky, drop_cnt = 0; decim counter, lane index, word count = 0.
//  Input stage: adpin/adcovr registered every clk50 edge into in_reg; all logic works on in_reg.
//  Decimation: counter counts 0..decim; sample accepted when counter==0; decim=0 accepts every sample.
//  Config (trig_mode, trig_rising, trig_level, decim, frame_len) latched on leaving IDLE; later changes ignored.
//  FSM:
//   IDLE: arm=1 & trig_mode=0 -> CAPTURE; arm=1 & trig_mode=1 -> WAIT_TRIG. On exit: clear ovr_sticky,
//         drop_cnt, lane index, decim counter, word count.
//   WAIT_TRIG: on accepted samples compare prev vs cur: rising = prev<level & cur>=level; falling = prev>=level
//         & cur<level. First accepted sample after arm only loads prev (never triggers). On trigger -> CAPTURE,
//         triggering sample becomes lane 0 of the first word.
//   CAPTURE: pack accepted samples; on final lane, word complete. Free-run: continue indefinitely.
//         Triggered: word count++ per completed word (dropped words included); count==frame_len -> DONE.
//   DONE: done=1, no writes; arm=0 -> IDLE.
//  arm=0 in WAIT_TRIG/CAPTURE -> IDLE next edge; partial word discarded, no wren.
//  Triggered with frame_len=0: WAIT_TRIG -> DONE on trigger, no words written.
//  Word completion: if afull=0, wren=1 for one cycle with odata; if afull=1, wren stays 0, drop_cnt++ (sat).
//  Latency: adpin of final lane sampled at edge k -> odata/wren valid after edge k+2.
//  ovr_sticky set when an accepted sample in CAPTURE has adcovr=1; cleared only on leaving IDLE or reset.
//  Reset mid-operation: immediate return to reset values, no wren.
// STRUCTURE
//  Package adc_capture_pkg: state enum {IDLE, WAIT_TRIG, CAPTURE, DONE}; MODE_FREE=1'b0, MODE_TRIG=1'b1.
//  Sub-module adc_trig_det: holds prev sample + primed flag, outputs one-cycle trigger hit on accepted samples.
//  Top holds input reg, decimator, lane packer, FSM, counters.
// TESTING
//  Free-run, decim=0, ramp 0,1,2.. -> words {3,2,1,0},{7,6,5,4}; wren every 4th cycle, latency 2 edges.
//  Free-run, decim=2, ramp -> first word lanes 0,3,6,9; wren every 12 cycles.
//  Triggered rising, level=512, ramp from 500, frame_len=3 -> first word lane0=512; exactly 3 wrens; done=1.
//  Same with afull=1 over 2nd word -> 2 wrens, drop_cnt=1, done after 3 word periods.
//  arm dropped after 2 lanes in CAPTURE -> no wren, busy=0 next cycle; re-arm clears ovr_sticky/drop_cnt.
//  adcovr pulse on accepted sample -> ovr_sticky=1 held; frame_len=0 -> done on trigger, zero wrens.

Source files
------------

// File: rtl/adc_capture_pkg.sv
// adc_capture_pkg: shared FSM state encodings and capture mode constants
package adc_capture_pkg;
  typedef logic [1:0] state_t;
  localparam state_t IDLE      = 2'd0;
  localparam state_t WAIT_TRIG = 2'd1;
  localparam state_t CAPTURE   = 2'd2;
  localparam state_t DONE      = 2'd3;
  localparam logic MODE_FREE = 1'b0;
  localparam logic MODE_TRIG = 1'b1;
endpackage

// File: rtl/adc_capture_trig_det.sv
// adc_trig_det: level-crossing detector over accepted samples, first sample after clear only primes
module adc_trig_det #(
  parameter int SAMPLE_W = 10
) (
  input  logic                clk50,
  input  logic                reset,
  input  logic                clr,
  input  logic                en,
  input  logic                rising,
  input  logic [SAMPLE_W-1:0] cur,
  input  logic [SAMPLE_W-1:0] level,
  output logic                hit
);
  logic [SAMPLE_W-1:0] prev;
  logic                primed;
  always_ff @(posedge clk50) begin
    if (reset || clr) begin
      prev   <= '0;
      primed <= 1'b0;
    end else if (en) begin
      prev   <= cur;
      primed <= 1'b1;
    end
  end
  assign hit = en && primed && (rising ? (prev < level && cur >= level)
                                       : (prev >= level && cur < level));
endmodule

// File: rtl/adc_capture.sv
// adc_capture: registers ADC samples, decimates, packs LANES samples per FIFO word, free-run or triggered frames
module adc_capture
  import adc_capture_pkg::*;
#(
  parameter int SAMPLE_W = 10,
  parameter int LANES    = 4,
  parameter int DECIM_W  = 8,
  parameter int LEN_W    = 16,
  localparam int WORD_W  = SAMPLE_W * LANES
) (
  input  logic                clk50,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] adpin,
  input  logic                adcovr,
  input  logic                arm,
  input  logic                trig_mode,
  input  logic                trig_rising,
  input  logic [SAMPLE_W-1:0] trig_level,
  input  logic [DECIM_W-1:0]  decim,
  input  logic [LEN_W-1:0]    frame_len,
  input  logic                afull,
  output logic [WORD_W-1:0]   odata,
  output logic                wren,
  output logic                busy,
  output logic                done,
  output logic                ovr_sticky,
  output logic [15:0]         drop_cnt
);
  localparam int LW = LANES > 1 ? $clog2(LANES) : 1;
  state_t                    state, nxt;
  logic [SAMPLE_W-1:0]       in_reg, level_l;
  logic                      ovr_reg, mode_l, rising_l;
  logic [DECIM_W-1:0]        decim_l, dcnt;
  logic [LEN_W-1:0]          len_l, wcnt;
  logic [LW-1:0]             lane;
  logic [WORD_W-1:0]         shreg, pack_word, shifted;
  logic [WORD_W+SAMPLE_W-1:0] cat;
  logic                      word_vld, leave, accept, hit, pack, last, word_end, frame_end;
  assign leave     = state == IDLE && arm;
  assign busy      = state == WAIT_TRIG || state == CAPTURE;
  assign done      = state == DONE;
  assign accept    = busy && dcnt == '0;
  assign pack      = accept && (state == CAPTURE || (hit && len_l != '0));
  assign last      = lane == LW'(LANES - 1);
  assign cat       = {in_reg, shreg};
  assign shifted   = WORD_W'(cat >> SAMPLE_W);
  // word bookkeeping happens one cycle after packing, aligned with the FIFO write
  assign word_end  = word_vld && state == CAPTURE;
  assign frame_end = word_end && mode_l == MODE_TRIG && wcnt + 1'b1 == len_l;
  adc_trig_det #(.SAMPLE_W(SAMPLE_W)) u_trig (
    .clk50(clk50), .reset(reset), .clr(leave), .en(accept && state == WAIT_TRIG),
    .rising(rising_l), .cur(in_reg), .level(level_l), .hit(hit)
  );
  always_comb begin
    nxt = (state != IDLE && !arm) ? IDLE :
          leave ? (trig_mode == MODE_TRIG ? WAIT_TRIG : CAPTURE) :
          (state == WAIT_TRIG && hit) ? (len_l == '0 ? DONE : CAPTURE) :
          frame_end ? DONE : state;
  end
  always_ff @(posedge clk50) begin
    if (reset) begin
      state <= IDLE;
      in_reg <= '0;
      ovr_reg <= 1'b0;
      mode_l <= MODE_FREE;
      rising_l <= 1'b0;
      level_l <= '0;
      decim_l <= '0;
      len_l <= '0;
      dcnt <= '0;
      lane <= '0;
      wcnt <= '0;
      shreg <= '0;
      pack_word <= '0;
      word_vld <= 1'b0;
      odata <= '0;
      wren <= 1'b0;
      ovr_sticky <= 1'b0;
      drop_cnt <= '0;
    end else begin
      state <= nxt;
      in_reg <= adpin;
      ovr_reg <= adcovr;
      wren <= word_end && !afull;
      if (word_end && !afull) odata <= pack_word;
      if (word_end && afull && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
      if (word_end) wcnt <= wcnt + 1'b1;
      word_vld <= pack && last;
      if (busy) dcnt <= dcnt == decim_l ? '0 : dcnt + 1'b1;
      if (pack) begin
        shreg <= shifted;
        lane <= last ? '0 : lane + 1'b1;
        if (last) pack_word <= shifted;
        if (ovr_reg) ovr_sticky <= 1'b1;
      end
      if (leave) begin
        mode_l <= trig_mode;
        rising_l <= trig_rising;
        level_l <= trig_level;
        decim_l <= decim;
        len_l <= frame_len;
        ovr_sticky <= 1'b0;
        drop_cnt <= '0;
        lane <= '0;
        dcnt <= '0;
        wcnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_adc_capture.sv
// tb_adc_capture: directed checks of free-run, decimated, triggered, afull-drop, abort and reset behaviour
module tb_adc_capture;
  logic        clk, reset, adcovr, arm, trig_mode, trig_rising, afull;
  logic [9:0]  adpin, trig_level;
  logic [7:0]  decim;
  logic [15:0] frame_len, drop_cnt;
  logic [39:0] odata;
  logic        wren, busy, done, ovr_sticky;
  logic [39:0] words[$];
  int          wtimes[$];
  int          pc, a, v, dv, tests, fails;
  adc_capture dut (
    .clk50(clk), .reset(reset), .adpin(adpin), .adcovr(adcovr), .arm(arm),
    .trig_mode(trig_mode), .trig_rising(trig_rising), .trig_level(trig_level),
    .decim(decim), .frame_len(frame_len), .afull(afull), .odata(odata), .wren(wren),
    .busy(busy), .done(done), .ovr_sticky(ovr_sticky), .drop_cnt(drop_cnt)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial pc = 0;
  always @(posedge clk) pc <= pc + 1;
  always @(negedge clk) if (wren) begin
    words.push_back(odata);
    wtimes.push_back(pc);
  end
  function automatic logic [39:0] mk(input int l0, l1, l2, l3);
    return {10'(l3), 10'(l2), 10'(l1), 10'(l0)};
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cfg(input logic m, input logic r, input int lvl, input int dec, input int len);
    trig_mode = m;
    trig_rising = r;
    trig_level = 10'(lvl);
    decim = 8'(dec);
    frame_len = 16'(len);
  endtask
  task automatic start(input int s, input int d);
    words.delete();
    wtimes.delete();
    @(negedge clk);
    adpin = 10'(s);
    arm = 1'b1;
    a = pc;
    v = s + d;
    dv = d;
  endtask
  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      adpin = 10'(v);
      v += dv;
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    tests = 0; fails = 0;
    reset = 1'b1; arm = 1'b0; adcovr = 1'b0; afull = 1'b0; adpin = '0;
    cfg(1'b0, 1'b1, 0, 0, 0);
    idle(3);
    chk("rst_odata", odata, 0);
    chk("rst_wren", wren, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovr", ovr_sticky, 0);
    chk("rst_drop", drop_cnt, 0);
    reset = 1'b0;
    idle(2);
    // free-run, no decimation
    start(0, 1);
    run(9);
    chk("fr_busy", busy, 1);
    @(negedge clk) arm = 1'b0;
    idle(3);
    chk("fr_nwords", words.size(), 2);
    chk("fr_word0", words[0], mk(0, 1, 2, 3));
    chk("fr_word1", words[1], mk(4, 5, 6, 7));
    chk("fr_latency", wtimes[0] - a, 6);
    chk("fr_gap", wtimes[1] - wtimes[0], 4);
    chk("fr_idle_busy", busy, 0);
    // free-run, decim=2
    cfg(1'b0, 1'b1, 0, 2, 0);
    start(0, 1);
    run(23);
    @(negedge clk) arm = 1'b0;
    idle(3);
    chk("dec_nwords", words.size(), 2);
    chk("dec_word0", words[0], mk(0, 3, 6, 9));
    chk("dec_word1", words[1], mk(12, 15, 18, 21));
    chk("dec_latency", wtimes[0] - a, 12);
    chk("dec_gap", wtimes[1] - wtimes[0], 12);
    // triggered rising, frame of 3 words
    cfg(1'b1, 1'b1, 512, 0, 3);
    start(500, 1);
    run(30);
    chk("trg_done", done, 1);
    chk("trg_busy", busy, 0);
    chk("trg_nwords", words.size(), 3);
    chk("trg_word0", words[0], mk(512, 513, 514, 515));
    chk("trg_word2", words[2], mk(520, 521, 522, 523));
    chk("trg_gap", wtimes[1] - wtimes[0], 4);
    @(negedge clk) arm = 1'b0;
    idle(1);
    chk("trg_done_clr", done, 0);
    // first accepted sample must only prime the detector
    cfg(1'b1, 1'b1, 512, 0, 3);
    start(512, 1);
    run(10);
    chk("prime_wait", busy, 1);
    chk("prime_nwords", words.size(), 0);
    @(negedge clk) arm = 1'b0;
    idle(2);
    // triggered with afull over second word
    cfg(1'b1, 1'b1, 512, 0, 3);
    start(500, 1);
    run(20);
    afull = 1'b1;
    run(2);
    afull = 1'b0;
    run(3);
    chk("af_done_early", done, 0);
    run(1);
    chk("af_done", done, 1);
    run(4);
    chk("af_nwords", words.size(), 2);
    chk("af_drop", drop_cnt, 1);
    chk("af_word0", words[0], mk(512, 513, 514, 515));
    chk("af_word1", words[1], mk(520, 521, 522, 523));
    @(negedge clk) arm = 1'b0;
    idle(2);
    chk("af_drop_held", drop_cnt, 1);
    // overrange on an accepted sample, then abort after two lanes
    cfg(1'b0, 1'b1, 0, 0, 0);
    start(0, 1);
    run(1);
    adcovr = 1'b1;
    run(1);
    adcovr = 1'b0;
    chk("ovr_before", ovr_sticky, 0);
    run(1);
    chk("ovr_set", ovr_sticky, 1);
    arm = 1'b0;
    idle(1);
    chk("abort_busy", busy, 0);
    idle(6);
    chk("abort_nwords", words.size(), 0);
    chk("ovr_held", ovr_sticky, 1);
    // falling trigger with frame_len=0, re-arm clears sticky state
    cfg(1'b1, 1'b0, 100, 0, 0);
    start(103, -1);
    run(1);
    chk("rearm_ovr", ovr_sticky, 0);
    chk("rearm_drop", drop_cnt, 0);
    run(4);
    chk("fl0_done_early", done, 0);
    run(1);
    chk("fl0_done", done, 1);
    idle(4);
    chk("fl0_nwords", words.size(), 0);
    @(negedge clk) arm = 1'b0;
    idle(2);
    // reset while a completed word is in flight
    cfg(1'b0, 1'b1, 0, 0, 0);
    start(0, 1);
    run(5);
    reset = 1'b1;
    idle(2);
    chk("rstmid_nwords", words.size(), 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_wren", wren, 0);
    reset = 1'b0;
    arm = 1'b0;
    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
